// File: rtl/clct_cfeb_busy_gen.sv
// Per-CFEB dead-time busy generator that feeds back into the best-1-of-7 CLCT sorter.
// Optional feature: define CLCT_BUSY_NEIGHBOR_EN to also mark edge-adjacent CFEBs busy.
module clct_cfeb_busy_gen #(
  parameter int MXCFEB  = 7,
  parameter int MXKEYBX = 8,
  parameter int MXDTB   = 4
) (
  input  logic               clock,
  input  logic               global_reset,
  input  logic               take,
  input  logic [MXKEYBX-1:0] take_key,
  input  logic [MXDTB-1:0]   dead_time,
  input  logic [MXCFEB-1:0]  cfeb_en,
  output logic [MXCFEB-1:0]  bsy,
  output logic               all_busy,
  output logic               bad_key
);

  logic [MXDTB-1:0]  cnt_q [MXCFEB];
  logic [MXDTB-1:0]  cnt_d [MXCFEB];
  logic [MXCFEB-1:0] bsy_q, bsy_d;
  logic              all_busy_q, all_busy_d;
  logic              bad_key_q, bad_key_d;
  logic [MXCFEB-1:0] load;
  logic [2:0]        key_cfeb;
  logic [4:0]        key_hs;

  assign key_cfeb = take_key[MXKEYBX-1:MXKEYBX-3];
  assign key_hs   = take_key[4:0];

  // Index 7 matches no loop position, so a bad key loads nothing.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < MXCFEB; i++) begin
      if (take && key_cfeb == 3'(i)) load[i] = 1'b1;
`ifdef CLCT_BUSY_NEIGHBOR_EN
      if (take && (i + 1 < MXCFEB) && key_cfeb == 3'(i + 1) && key_hs <= 5'd1)
        load[i] = 1'b1;
      if (take && (i > 0) && key_cfeb == 3'(i - 1) && key_hs >= 5'd30)
        load[i] = 1'b1;
`endif
    end
  end

  always_comb begin
    bsy_d = '0;
    for (int unsigned i = 0; i < MXCFEB; i++) begin
      if (global_reset)
        cnt_d[i] = '0;
      else if (load[i])
        cnt_d[i] = dead_time;
      else if (cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - MXDTB'(1);
      else
        cnt_d[i] = cnt_q[i];
      bsy_d[i] = !global_reset && ((cnt_d[i] != '0) || !cfeb_en[i]);
    end
    all_busy_d = &bsy_d;
    bad_key_d  = !global_reset && take && (key_cfeb == 3'd7);
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      for (int unsigned i = 0; i < MXCFEB; i++) cnt_q[i] <= '0;
      bsy_q      <= '0;
      all_busy_q <= 1'b0;
      bad_key_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < MXCFEB; i++) cnt_q[i] <= cnt_d[i];
      bsy_q      <= bsy_d;
      all_busy_q <= all_busy_d;
      bad_key_q  <= bad_key_d;
    end
  end

  assign bsy      = bsy_q;
  assign all_busy = all_busy_q;
  assign bad_key  = bad_key_q;

endmodule

// File: tb/tb_clct_cfeb_busy_gen.sv
// Directed vector bench for clct_cfeb_busy_gen; neighbour expectations follow CLCT_BUSY_NEIGHBOR_EN.
module tb_clct_cfeb_busy_gen;

  logic       clock = 1'b0;
  logic       global_reset;
  logic       take;
  logic [7:0] take_key;
  logic [3:0] dead_time;
  logic [6:0] cfeb_en;
  logic [6:0] bsy;
  logic       all_busy;
  logic       bad_key;

  int checks   = 0;
  int failures = 0;

  clct_cfeb_busy_gen #(.MXCFEB(7), .MXKEYBX(8), .MXDTB(4)) dut (
    .clock        (clock),
    .global_reset (global_reset),
    .take         (take),
    .take_key     (take_key),
    .dead_time    (dead_time),
    .cfeb_en      (cfeb_en),
    .bsy          (bsy),
    .all_busy     (all_busy),
    .bad_key      (bad_key)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic       tk;
    logic [7:0] key;
    logic [3:0] dt;
    logic [6:0] en;
    logic [6:0] exp_bsy;
    logic       exp_all;
    logic       exp_bad;
  } vec_t;

  vec_t vecs[$];

`ifdef CLCT_BUSY_NEIGHBOR_EN
  localparam logic [6:0] NB_3_31 = 7'h18;
  localparam logic [6:0] NB_3_0  = 7'h0C;
`else
  localparam logic [6:0] NB_3_31 = 7'h08;
  localparam logic [6:0] NB_3_0  = 7'h08;
`endif

  function automatic void add(string name, logic rst, logic tk, logic [7:0] key, logic [3:0] dt,
                              logic [6:0] en, logic [6:0] eb, logic ea, logic ebad);
    vec_t v;
    v.name = name; v.rst = rst; v.tk = tk; v.key = key; v.dt = dt; v.en = en;
    v.exp_bsy = eb; v.exp_all = ea; v.exp_bad = ebad;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic rst, logic tk, logic [7:0] key, logic [3:0] dt, logic [6:0] en);
    global_reset = rst; take = tk; take_key = key; dead_time = dt; cfeb_en = en;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(string name, logic [6:0] eb, logic ea, logic ebad);
    checks++;
    if (bsy !== eb || all_busy !== ea || bad_key !== ebad) begin
      failures++;
      $display("FAIL %s: got bsy=%h all_busy=%b bad_key=%b, want bsy=%h all_busy=%b bad_key=%b",
               name, bsy, all_busy, bad_key, eb, ea, ebad);
    end
  endtask

  initial begin
    int high_cnt, first_hi, last_hi;

    add("reset",        1, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("idle_after",   0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    // take CFEB 2, dead_time 4: exactly four busy cycles
    add("take2",        0, 1, {3'd2, 5'd10}, 4'd4, 7'h7F, 7'h04, 0, 0);
    add("take2_w1",     0, 0, 8'h00, 4'd0, 7'h7F, 7'h04, 0, 0);
    add("take2_w2",     0, 0, 8'h00, 4'd0, 7'h7F, 7'h04, 0, 0);
    add("take2_w3",     0, 0, 8'h00, 4'd0, 7'h7F, 7'h04, 0, 0);
    add("take2_end",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("take2_sat",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("bad_key",      0, 1, {3'd7, 5'd0}, 4'd5, 7'h7F, 7'h00, 0, 1);
    add("bad_key_end",  0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("dt_zero",      0, 1, {3'd4, 5'd3}, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("dt_zero_post", 0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    // CFEB 0 disabled, then fill CFEBs 1..6 with overlapping windows
    add("dis0",         0, 0, 8'h00, 4'd0, 7'h7E, 7'h01, 0, 0);
    add("fill1",        0, 1, {3'd1, 5'd10}, 4'd8, 7'h7E, 7'h03, 0, 0);
    add("fill2",        0, 1, {3'd2, 5'd10}, 4'd8, 7'h7E, 7'h07, 0, 0);
    add("fill3",        0, 1, {3'd3, 5'd10}, 4'd8, 7'h7E, 7'h0F, 0, 0);
    add("fill4",        0, 1, {3'd4, 5'd10}, 4'd8, 7'h7E, 7'h1F, 0, 0);
    add("fill5",        0, 1, {3'd5, 5'd10}, 4'd8, 7'h7E, 7'h3F, 0, 0);
    add("fill6",        0, 1, {3'd6, 5'd10}, 4'd8, 7'h7E, 7'h7F, 1, 0);
    add("all_w1",       0, 0, 8'h00, 4'd0, 7'h7E, 7'h7F, 1, 0);
    add("all_w2",       0, 0, 8'h00, 4'd0, 7'h7E, 7'h7F, 1, 0);
    add("all_drop",     0, 0, 8'h00, 4'd0, 7'h7E, 7'h7D, 0, 0);
    add("reen_resid",   0, 0, 8'h00, 4'd0, 7'h7F, 7'h78, 0, 0);
    add("rst_mid",      1, 0, 8'h00, 4'd0, 7'h7E, 7'h00, 0, 0);
    add("rst_clear",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    // reset three cycles into a CFEB 3 window, with a coincident take discarded
    add("take3",        0, 1, {3'd3, 5'd10}, 4'd10, 7'h7F, 7'h08, 0, 0);
    add("take3_w1",     0, 0, 8'h00, 4'd0, 7'h7F, 7'h08, 0, 0);
    add("take3_w2",     0, 0, 8'h00, 4'd0, 7'h7F, 7'h08, 0, 0);
    add("rst_take",     1, 1, {3'd3, 5'd10}, 4'd10, 7'h7F, 7'h00, 0, 0);
    add("post_rst1",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("post_rst2",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    // upper edge half-strip: neighbour CFEB 4 only when the option is built in
    add("nb_3_31",      0, 1, {3'd3, 5'd31}, 4'd5, 7'h7F, NB_3_31, 0, 0);
    add("nb_3_31_w1",   0, 0, 8'h00, 4'd0, 7'h7F, NB_3_31, 0, 0);
    add("nb_3_31_w2",   0, 0, 8'h00, 4'd0, 7'h7F, NB_3_31, 0, 0);
    add("nb_3_31_w3",   0, 0, 8'h00, 4'd0, 7'h7F, NB_3_31, 0, 0);
    add("nb_3_31_w4",   0, 0, 8'h00, 4'd0, 7'h7F, NB_3_31, 0, 0);
    add("nb_3_31_end",  0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("nb_0_0",       0, 1, {3'd0, 5'd0}, 4'd2, 7'h7F, 7'h01, 0, 0);
    add("nb_0_0_w1",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h01, 0, 0);
    add("nb_0_0_end",   0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("nb_3_0",       0, 1, {3'd3, 5'd0}, 4'd1, 7'h7F, NB_3_0, 0, 0);
    add("nb_3_0_end",   0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    add("nb_6_31",      0, 1, {3'd6, 5'd31}, 4'd1, 7'h7F, 7'h40, 0, 0);
    add("nb_6_31_end",  0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);
    // disabling a counting CFEB keeps its counter running
    add("dis_take4",    0, 1, {3'd4, 5'd10}, 4'd3, 7'h7F, 7'h10, 0, 0);
    add("dis_cnt4",     0, 0, 8'h00, 4'd0, 7'h6F, 7'h10, 0, 0);
    add("reen_cnt4",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h10, 0, 0);
    add("reen_end4",    0, 0, 8'h00, 4'd0, 7'h7F, 7'h00, 0, 0);

    drive(1, 0, 8'h00, 4'd0, 7'h7F);
    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].tk, vecs[i].key, vecs[i].dt, vecs[i].en);
      tick();
      check_out(vecs[i].name, vecs[i].exp_bsy, vecs[i].exp_all, vecs[i].exp_bad);
    end

    // retake CFEB 5 three cycles into a 6-cycle window: one unbroken 9-cycle busy
    high_cnt = 0; first_hi = -1; last_hi = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 0 || c == 3) drive(0, 1, {3'd5, 5'd10}, 4'd6, 7'h7F);
      else                  drive(0, 0, 8'h00, 4'd0, 7'h7F);
      tick();
      if (bsy[5]) begin
        high_cnt++;
        if (first_hi < 0) first_hi = c;
        last_hi = c;
      end
    end
    checks++;
    if (high_cnt != 9) begin
      failures++;
      $display("FAIL retake5_count: got %0d busy cycles, want 9", high_cnt);
    end
    checks++;
    if (first_hi != 0 || last_hi != 8) begin
      failures++;
      $display("FAIL retake5_span: got first=%0d last=%0d, want first=0 last=8", first_hi, last_hi);
    end
    check_out("retake5_idle", 7'h00, 0, 0);

    // back-to-back takes on CFEBs 0 and 6 run independent windows
    drive(0, 1, {3'd0, 5'd10}, 4'd2, 7'h7F); tick();
    check_out("b2b_a", 7'h01, 0, 0);
    drive(0, 1, {3'd6, 5'd10}, 4'd3, 7'h7F); tick();
    check_out("b2b_b", 7'h41, 0, 0);
    drive(0, 0, 8'h00, 4'd0, 7'h7F); tick();
    check_out("b2b_c", 7'h40, 0, 0);
    tick();
    check_out("b2b_d", 7'h40, 0, 0);
    tick();
    check_out("b2b_e", 7'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clct_cfeb_busy_gen.md
# clct_cfeb_busy_gen

Generates the per-CFEB busy flags that the best-1-of-7 CLCT pattern sorter consumes. When a CLCT is accepted, the CFEB that supplied it is marked busy for a programmable dead time, so later sorts skip it while its drift-time hits are still active. The block sits downstream of the sorter's best-key output and feeds the sorter's seven busy inputs back on the next cycles, closing the busy loop.

## Interface
- MXCFEB, 7, number of CFEBs / busy outputs
- MXKEYBX, 8, width of the accepted key: {cfeb[2:0], hs[4:0]}
- MXDTB, 4, dead-time counter width
- clock  in  1  system clock, all logic on rising edge
- global_reset  in  1  synchronous, active-high; clears all state
- take  in  1  single-cycle strobe: sorter result accepted as a CLCT
- take_key  in  MXKEYBX  accepted best key; bits [7:5] CFEB index, [4:0] half-strip within CFEB
- dead_time  in  MXDTB  busy duration in clocks, sampled on take
- cfeb_en  in  MXCFEB  1 = CFEB enabled; disabled CFEBs held busy
- bsy  out  MXCFEB  registered per-CFEB busy, bit i drives sorter bsy<i>
- all_busy  out  1  registered AND of bsy
- bad_key  out  1  registered one-cycle pulse: take with CFEB index 7

## Operation
- Per CFEB i: down-counter cnt[i] (MXDTB bits), reset 0.
- Each cycle, per i, in priority order:
  - global_reset: cnt[i] <= 0.
  - take, index == i (or neighbour hit, see Configuration): cnt[i] <= dead_time. A reload while counting restarts the window.
  - cnt[i] != 0: cnt[i] <= cnt[i] - 1. Saturates at 0; never wraps.
- bsy[i] registered: (next cnt[i] != 0) | !cfeb_en[i].
- CFEB index 7: no counter loaded, bad_key pulses 1 the following cycle.
- dead_time = 0 on take: no busy produced, not an error.
- take while the addressed CFEB is already busy is legal. The sorter never produces it; the block still reloads.
- Disabling a CFEB does not clear its counter. Re-enabling shows any residual busy time.

## Timing
- take at edge N: bsy[c] = 1 for cycles N+1 … N+dead_time, then 0 at N+dead_time+1.
- Back-to-back takes on different CFEBs: independent windows.
- Take on the same CFEB at N+k, with k ≤ dead_time: bsy[c] stays 1 through N+k+dead_time with no gap.
- cfeb_en change at edge N: reflected on bsy at N+1.
- Reset values: bsy = ~cfeb_en after the first post-reset edge, all-zero counters, all_busy = &(~cfeb_en), bad_key = 0. During reset, bsy is driven to 0.
- global_reset mid-window: bsy[i] drops at the next edge. A take coincident with reset is discarded.
- Outputs are register-driven only. Sorter path: take → bsy is exactly 1 clock.

## Configuration
- CLCT_BUSY_NEIGHBOR_EN defined:
  - a take with hs ≤ 1 and c > 0 also loads cnt[c-1];
  - a take with hs ≥ 30 and c < 6 also loads cnt[c+1].
  - Both load the same dead_time in the same cycle. Edge CFEBs 0 and 6 have no outer neighbour.
- Undefined: only cnt[c] loads; hs bits are ignored.

## Test plan
- Reset, cfeb_en=7'h7F, take_key={3'd2,5'd10}, dead_time=4 → bsy=7'h04 for exactly 4 cycles after the take, then 7'h00; bad_key stays 0.
- Take CFEB 5 with dead_time=6, then retake CFEB 5 with dead_time=6 three cycles later → bsy[5] high continuously for 9 cycles.
- Take key {3'd7,5'd0} → bad_key one pulse; bsy unchanged. Take with dead_time=0 → bsy stays 0.
- cfeb_en=7'h7E, no takes → bsy=7'h01, all_busy=0. Takes on CFEBs 1–6 with dead_time=8 on consecutive cycles → all_busy=1 for the overlap of the windows.
- Take CFEB 3 with dead_time=10; assert global_reset 3 cycles later → bsy=0 at the next edge. After reset releases, no residual busy.
- With CLCT_BUSY_NEIGHBOR_EN: take {3'd3,5'd31} with dead_time=5 → bsy=7'h18 for 5 cycles. Take {3'd0,5'd0} → bsy=7'h01 only. Without the macro: take {3'd3,5'd31} → bsy=7'h08.
